// File: rtl/led_matrix_scanner_if.sv
// Frame input / scan output bundle for led_matrix_scanner.
// The duty signal exists only when LED_PWM_EN is defined.
interface led_matrix_scanner_if #(
   parameter int unsigned ROWS  = 8,
   parameter int unsigned COLS  = 8
`ifdef LED_PWM_EN
   ,parameter int unsigned DWELL = 1000
`endif
);
   logic                      ena;
   logic                      frame_valid;
   logic [ROWS*COLS-1:0]      frame_data;
   logic                      frame_ready;
   logic [ROWS-1:0]           rows;
   logic [COLS-1:0]           cols;
   logic [$clog2(ROWS)-1:0]   row_idx;
   logic                      frame_done;
`ifdef LED_PWM_EN
   logic [$clog2(DWELL+1)-1:0] duty;

   modport master (
      output ena, frame_valid, frame_data, duty,
      input  frame_ready, rows, cols, row_idx, frame_done
   );
   modport slave (
      input  ena, frame_valid, frame_data, duty,
      output frame_ready, rows, cols, row_idx, frame_done
   );
`else
   modport master (
      output ena, frame_valid, frame_data,
      input  frame_ready, rows, cols, row_idx, frame_done
   );
   modport slave (
      input  ena, frame_valid, frame_data,
      output frame_ready, rows, cols, row_idx, frame_done
   );
`endif
endinterface

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed LED matrix scanner with double-buffered frame memory.
// Optional per-row PWM duty control is enabled by defining LED_PWM_EN.
module led_matrix_scanner #(
   parameter int unsigned ROWS  = 8,
   parameter int unsigned COLS  = 8,
   parameter int unsigned DWELL = 1000,
   parameter int unsigned BLANK = 8
) (
   input logic                 clk,
   input logic                 rst,
   led_matrix_scanner_if.slave bus
);
   localparam int unsigned RW   = $clog2(ROWS);
   localparam int unsigned N    = ROWS * COLS;
   localparam int unsigned MAXC = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   typedef enum logic [1:0] {StIdle, StBlank, StDwell} state_e;

   state_e          r_state, w_state_d;
   logic [RW-1:0]   r_row_idx, w_row_idx_d;
   logic [CW-1:0]   r_cnt, w_cnt_d;
   logic [N-1:0]    r_display, w_display_d;
   logic [N-1:0]    r_shadow, w_shadow_d;
   logic            r_full, w_full_d;
   logic            r_frame_done, w_frame_done_d;
   logic            w_accept, w_copy, w_enter_dwell, w_lit;
   logic [COLS-1:0] w_row_data [ROWS];

`ifdef LED_PWM_EN
   localparam int unsigned DW = $clog2(DWELL + 1);
   logic [DW-1:0] r_duty, w_duty_d;
`endif

   always_comb begin
      w_state_d      = r_state;
      w_row_idx_d    = r_row_idx;
      w_cnt_d        = r_cnt;
      w_frame_done_d = 1'b0;
      w_copy         = 1'b0;
      w_enter_dwell  = 1'b0;
      case (r_state)
         StIdle: begin
            w_copy = r_full;
            if (bus.ena) begin
               w_row_idx_d = '0;
               w_cnt_d     = '0;
               if (BLANK == 0) begin
                  w_state_d     = StDwell;
                  w_enter_dwell = 1'b1;
               end else begin
                  w_state_d = StBlank;
               end
            end
         end
         StBlank: begin
            if (r_cnt == CW'(BLANK - 1)) begin
               w_cnt_d       = '0;
               w_state_d     = StDwell;
               w_enter_dwell = 1'b1;
            end else begin
               w_cnt_d = r_cnt + CW'(1);
            end
         end
         StDwell: begin
            if (r_cnt == CW'(DWELL - 1)) begin
               w_cnt_d = '0;
               if (r_row_idx == RW'(ROWS - 1)) begin
                  w_row_idx_d    = '0;
                  w_frame_done_d = 1'b1;
                  w_copy         = r_full;
               end else begin
                  w_row_idx_d = r_row_idx + RW'(1);
               end
               if (BLANK == 0) begin
                  w_enter_dwell = 1'b1;
               end else begin
                  w_state_d = StBlank;
               end
            end else begin
               w_cnt_d = r_cnt + CW'(1);
            end
         end
         default: w_state_d = StIdle;
      endcase

      // Disable wins over everything; an idle buffer swap still goes ahead.
      if (!bus.ena) begin
         w_state_d      = StIdle;
         w_row_idx_d    = '0;
         w_cnt_d        = '0;
         w_frame_done_d = 1'b0;
         w_enter_dwell  = 1'b0;
         w_copy         = w_copy && (r_state == StIdle);
      end

      // Copy needs full=1 and accept needs full=0, so they never collide.
      w_accept    = bus.frame_valid && !r_full;
      w_display_d = w_copy ? r_shadow : r_display;
      w_shadow_d  = w_accept ? bus.frame_data : r_shadow;
      w_full_d    = w_copy ? 1'b0 : (w_accept ? 1'b1 : r_full);
`ifdef LED_PWM_EN
      w_duty_d    = w_enter_dwell ? bus.duty : r_duty;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= StIdle;
         r_row_idx    <= '0;
         r_cnt        <= '0;
         r_display    <= '0;
         r_shadow     <= '0;
         r_full       <= 1'b0;
         r_frame_done <= 1'b0;
`ifdef LED_PWM_EN
         r_duty       <= '0;
`endif
      end else begin
         r_state      <= w_state_d;
         r_row_idx    <= w_row_idx_d;
         r_cnt        <= w_cnt_d;
         r_display    <= w_display_d;
         r_shadow     <= w_shadow_d;
         r_full       <= w_full_d;
         r_frame_done <= w_frame_done_d;
`ifdef LED_PWM_EN
         r_duty       <= w_duty_d;
`endif
      end
   end

   for (genvar g = 0; g < ROWS; g++) begin : g_row_view
      assign w_row_data[g] = r_display[g*COLS +: COLS];
   end

`ifdef LED_PWM_EN
   assign w_lit = (r_state == StDwell) && (32'(r_cnt) < 32'(r_duty));
`else
   assign w_lit = (r_state == StDwell);
`endif

   assign bus.rows        = (r_state == StDwell) ? (ROWS'(1) << r_row_idx) : '0;
   assign bus.cols        = w_lit ? w_row_data[r_row_idx] : '0;
   assign bus.row_idx     = r_row_idx;
   assign bus.frame_done  = r_frame_done;
   assign bus.frame_ready = !r_full;
endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench for led_matrix_scanner: a frame-position model queues the expected
// outputs of every cycle and a negedge monitor compares them. Define LED_PWM_EN for duty tests.
module tb_led_matrix_scanner;
   localparam int R  = 4;
   localparam int C  = 4;
   localparam int D  = 4;
   localparam int B  = 2;
   localparam int RP = B + D;
   localparam int P  = R * RP;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

`ifdef LED_PWM_EN
   led_matrix_scanner_if #(.ROWS(R), .COLS(C), .DWELL(D)) bus ();
`else
   led_matrix_scanner_if #(.ROWS(R), .COLS(C)) bus ();
`endif

   led_matrix_scanner #(.ROWS(R), .COLS(C), .DWELL(D), .BLANK(B)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   // Model: scan position is just a cycle count within the frame period.
   bit          m_active;
   int          m_t;
   logic [15:0] m_display, m_shadow;
   bit          m_full, m_fd;
   int          m_duty;
   logic [11:0] exp_q [$];

   function automatic logic [11:0] model_out();
      logic [3:0]  rows_e = '0;
      logic [3:0]  cols_e = '0;
      logic [1:0]  ri_e   = '0;
      logic [15:0] tmp;
      int row, ph;
      if (m_active) begin
         row  = m_t / RP;
         ph   = m_t % RP;
         ri_e = 2'(row);
         if (ph >= B) begin
            rows_e = 4'(1 << row);
            tmp    = m_display >> (row * C);
            cols_e = tmp[3:0];
`ifdef LED_PWM_EN
            if ((ph - B) >= m_duty) cols_e = '0;
`endif
         end
      end
      return {rows_e, cols_e, ri_e, m_fd, !m_full};
   endfunction

   task automatic model_reset();
      m_active  = 0;
      m_t       = 0;
      m_display = '0;
      m_shadow  = '0;
      m_full    = 0;
      m_fd      = 0;
      m_duty    = 0;
   endtask

   always @(posedge rst) begin
      model_reset();
      if (exp_q.size() > 0) exp_q[exp_q.size()-1] = model_out();
   end

   always @(posedge clk) begin
      bit copy, acc;
      if (rst) begin
         model_reset();
      end else begin
         copy = !m_active && m_full;
         acc  = bus.frame_valid && !m_full;
         m_fd = 0;
         if (bus.ena) begin
            if (!m_active) begin
               m_active = 1;
               m_t      = 0;
            end else begin
               if (m_t == P - 1) begin
                  m_fd = 1;
                  if (m_full) copy = 1;
               end
               m_t = (m_t + 1) % P;
            end
         end else begin
            m_active = 0;
            m_t      = 0;
         end
         if (copy) begin
            m_display = m_shadow;
            m_full    = 0;
         end
         if (acc) begin
            m_shadow = bus.frame_data;
            m_full   = 1;
         end
`ifdef LED_PWM_EN
         if (m_active && (m_t % RP) == B) m_duty = int'(bus.duty);
`endif
      end
      exp_q.push_back(model_out());
   end

   // Monitor
   initial begin
      logic [11:0] e, g;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {bus.rows, bus.cols, bus.row_idx, bus.frame_done, bus.frame_ready};
            total++;
            if (g !== e) begin
               bad++;
               $display("FAIL outputs t=%0t got rows=%b cols=%b idx=%0d done=%b rdy=%b required rows=%b cols=%b idx=%0d done=%b rdy=%b",
                        $time, g[11:8], g[7:4], g[3:2], g[1], g[0],
                        e[11:8], e[7:4], e[3:2], e[1], e[0]);
            end
         end
      end
   end

   task automatic step(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(string name, logic [31:0] got, logic [31:0] req);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL %s got=%0h required=%0h", name, got, req);
      end
   endtask

   task automatic wait_row_lit(int row);
      int k = 0;
      while (!(int'(bus.row_idx) == row && bus.rows != 0) && k < 200) begin
         step();
         k++;
      end
      total++;
      if (k >= 200) begin
         bad++;
         $display("FAIL wait_row%0d got=timeout required=row lit", row);
      end
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_ready"}, 32'(bus.frame_ready), 32'd1);
      check({tag, "_rows"}, 32'(bus.rows), 32'd0);
      check({tag, "_cols"}, 32'(bus.cols), 32'd0);
      check({tag, "_idx"}, 32'(bus.row_idx), 32'd0);
      check({tag, "_done"}, 32'(bus.frame_done), 32'd0);
   endtask

   initial begin
      bus.ena         = 1'b0;
      bus.frame_valid = 1'b0;
      bus.frame_data  = '0;
`ifdef LED_PWM_EN
      bus.duty        = 3'd4;
`endif
      #1 rst = 1'b1;
      #1 check_reset_outputs("por");
      step(2);
      rst = 1'b0;
      step();

      // Disabled: a frame is absorbed into the display while outputs stay dark.
      bus.frame_valid = 1'b1;
      bus.frame_data  = 16'hFFFF;
      step();
      bus.frame_valid = 1'b0;
      step(10);

      bus.frame_valid = 1'b1;
      bus.frame_data  = 16'h8421;
      step();
      bus.frame_valid = 1'b0;
      step(2);
      bus.ena = 1'b1;
      step(3 * P + 4);

      // Mid-frame update with a second frame queued behind it.
      wait_row_lit(1);
      bus.frame_valid = 1'b1;
      bus.frame_data  = 16'h000F;
      step();
      bus.frame_data  = 16'h1234;
      step(2 * P + 10);
      bus.frame_valid = 1'b0;
      step(P);

      // Disable during row 2 dwell, then restart.
      wait_row_lit(2);
      step();
      bus.ena = 1'b0;
      step(5);
      bus.ena = 1'b1;
      step(P + 6);

      // Reset during row 3 with a pending shadow frame.
      wait_row_lit(3);
      bus.frame_valid = 1'b1;
      bus.frame_data  = 16'(($urandom & 16'hFFFE) | 16'h0001);
      step();
      bus.frame_valid = 1'b0;
      check("shadow_full_ready", 32'(bus.frame_ready), 32'd0);
      #2 rst = 1'b1;
      #1 check_reset_outputs("midrst");
      step(2);
      rst = 1'b0;
      step(P + 3);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         bus.ena         = ($urandom_range(0, 39) != 0);
         bus.frame_valid = ($urandom_range(0, 3) == 0);
         bus.frame_data  = 16'($urandom);
`ifdef LED_PWM_EN
         bus.duty        = 3'($urandom_range(0, 5));
`endif
         step();
      end
      bus.frame_valid = 1'b0;

`ifdef LED_PWM_EN
      bus.ena         = 1'b0;
      bus.frame_valid = 1'b1;
      bus.frame_data  = 16'hFFFF;
      step();
      bus.frame_valid = 1'b0;
      step(3);
      bus.duty = 3'd2;
      bus.ena  = 1'b1;
      step(P + 4);
      bus.duty = 3'd0;
      step(P + 8);
      bus.duty = 3'd7;
      step(P + 8);
`endif

      bus.ena = 1'b0;
      step(4);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
